// File: rtl/axi_read_pkg.sv
// ============================================================================
// Package     : axi_read_pkg
// Description : Shared types and helpers for the AXI read initiator: FSM state
//               encoding, default length width and ARLEN-to-beats conversion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_read_pkg;

    // Default width of the ARLEN field
    localparam int DEFAULT_LEN_W = 8;

    // Initiator FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // Number of beats in a burst for a given ARLEN (AXI encodes len-1)
    function automatic logic [31:0] beats_from_len(input logic [31:0] len);
        return len + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_rd_watchdog.sv
// ============================================================================
// Module      : axi_rd_watchdog
// Description : Idle-cycle watchdog for the read data phase. Counts enabled
//               cycles, restarts on clear, and flags expiry on the TIMEOUT-th
//               consecutive enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wd_cnt;

    // Expiry is reported in the cycle whose count already sits at TIMEOUT-1
    assign expire = enable && (wd_cnt == LAST);

    // Consecutive idle-cycle counter; clear has priority, expiry restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (clear || expire) begin
            wd_cnt <= '0;
        end else if (enable) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_read_initiator.sv
// ============================================================================
// Module      : axi_read_initiator
// Description : Manager-side AXI read control FSM. Issues AR for a locally
//               requested burst, accepts R beats, counts them against ARLEN
//               and reports done / length error / watchdog timeout pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_read_initiator
    import axi_read_pkg::*;
#(
    parameter int LEN_W   = DEFAULT_LEN_W,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    input  logic             stall,
    output logic             arvalid,
    output logic [LEN_W-1:0] arlen,
    input  logic             arready,
    input  logic             rvalid,
    input  logic             rlast,
    output logic             rready,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic             err_timeout,
    output logic [LEN_W:0]   beats
);

    localparam logic [LEN_W:0] BEATS_MAX = '1;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic             err_seen;

    logic beat;
    logic last_expected;
    logic wd_clear;
    logic wd_enable;
    logic wd_expire;

    assign req_ready = (state == IDLE);
    assign arvalid   = (state == ADDR);
    assign arlen     = len_q;
    assign rready    = (state == DATA) && !stall;
    assign busy      = (state != IDLE);

    assign beat = rvalid && rready;

    // The beat being accepted now is the one ARLEN says should carry rlast
    assign last_expected = (32'(beats) + 32'd1) == beats_from_len(32'(len_q));

    // Watchdog restarts on every accepted beat and while waiting on AR
    assign wd_clear  = (state == ADDR) || beat;
    assign wd_enable = (state == DATA) && !beat;

    axi_rd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // Burst control FSM with registered status pulses and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            beats       <= '0;
            err_seen    <= 1'b0;
            done        <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done        <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        len_q    <= req_len;
                        beats    <= '0;
                        err_seen <= 1'b0;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (arready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        if (beats != BEATS_MAX) begin
                            beats <= beats + 1'b1;
                        end
                        if (rlast) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            // rlast early or late; suppressed if already flagged
                            if (!last_expected && !err_seen) begin
                                err_len  <= 1'b1;
                                err_seen <= 1'b1;
                            end
                        end else if (last_expected && !err_seen) begin
                            // Expected final beat arrived without rlast: drain on
                            err_len  <= 1'b1;
                            err_seen <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_read_initiator.sv
// ============================================================================
// Module      : tb_axi_read_initiator
// Description : Self-checking bench for axi_read_initiator (LEN_W=8,
//               TIMEOUT=8). Table of directed bursts plus hand sequences for
//               timeout, backpressure, simultaneous events and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_read_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_len = '0;
    logic       req_ready;
    logic       stall = 1'b0;
    logic       arvalid;
    logic [7:0] arlen;
    logic       arready = 1'b0;
    logic       rvalid = 1'b0;
    logic       rlast = 1'b0;
    logic       rready;
    logic       busy;
    logic       done;
    logic       err_len;
    logic       err_timeout;
    logic [8:0] beats;

    axi_read_initiator #(
        .LEN_W   (8),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .stall       (stall),
        .arvalid     (arvalid),
        .arlen       (arlen),
        .arready     (arready),
        .rvalid      (rvalid),
        .rlast       (rlast),
        .rready      (rready),
        .busy        (busy),
        .done        (done),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .beats       (beats)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int rlast_at;
        int ar_delay;
        int exp_err_cnt;
        int exp_err_at;
        int exp_beats;
    } vec_t;

    vec_t vecs[8];

    int checks   = 0;
    int failures = 0;
    int n_done, n_err, n_to, done_at, err_at, cur_beat;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        n_done = 0; n_err = 0; n_to = 0; done_at = 0; err_at = 0; cur_beat = 0;
    endtask

    // Advance one clock and record any status pulse seen after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (done) begin n_done++; done_at = cur_beat; end
        if (err_len) begin n_err++; err_at = cur_beat; end
        if (err_timeout) n_to++;
    endtask

    // Accept a request and complete the AR handshake immediately
    task automatic start_burst(input int len);
        req_valid = 1'b1;
        req_len   = len[7:0];
        step();
        req_valid = 1'b0;
        arready   = 1'b1;
        step();
        arready   = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        int stable_bad;
        stable_bad = 0;
        clear_obs();
        check("req_ready_idle", int'(req_ready), 1);
        req_valid = 1'b1;
        req_len   = v.len[7:0];
        check("arvalid_before_accept", int'(arvalid), 0);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < v.ar_delay; i++) begin
            if (!arvalid || int'(arlen) != v.len) stable_bad++;
            step();
        end
        check("ar_stable", stable_bad, 0);
        check("arvalid", int'(arvalid), 1);
        check("arlen", int'(arlen), v.len);
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("rready_data", int'(rready), 1);
        for (int b = 1; b <= v.rlast_at; b++) begin
            cur_beat = b;
            rvalid   = 1'b1;
            rlast    = (b == v.rlast_at);
            step();
        end
        rvalid   = 1'b0;
        rlast    = 1'b0;
        cur_beat = 99;
        step();
        step();
        check("done_count", n_done, 1);
        check("done_at", done_at, v.rlast_at);
        check("err_len_count", n_err, v.exp_err_cnt);
        check("err_len_at", err_at, v.exp_err_at);
        check("timeout_count", n_to, 0);
        check("beats", int'(beats), v.exp_beats);
        check("busy_end", int'(busy), 0);
    endtask

    initial begin
        int k;
        //          len rlast  ard errs errat beats
        vecs[0] = '{7,   8,    0,  0,   0,    8};
        vecs[1] = '{3,   4,    5,  0,   0,    4};
        vecs[2] = '{3,   2,    0,  1,   2,    2};
        vecs[3] = '{1,   4,    1,  1,   2,    4};
        vecs[4] = '{0,   1,    2,  0,   0,    1};
        vecs[5] = '{2,   5,    0,  1,   3,    5};
        vecs[6] = '{5,   1,    0,  1,   1,    1};
        vecs[7] = '{255, 256,  0,  0,   0,    256};

        // Reset state
        #12;
        check("rst_arvalid", int'(arvalid), 0);
        check("rst_rready", int'(rready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_arlen", int'(arlen), 0);
        check("rst_beats", int'(beats), 0);
        check("rst_pulses", int'({done, err_len, err_timeout}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("rst_req_ready", int'(req_ready), 1);

        for (int i = 0; i < 8; i++) run_burst(vecs[i]);

        // Watchdog: no rvalid at all in DATA
        clear_obs();
        start_burst(3);
        k = 0;
        while (n_to == 0 && k < 20) begin k++; step(); end
        check("timeout_cycle", k, 8);
        check("timeout_no_done", n_done, 0);
        check("timeout_busy", int'(busy), 0);
        check("timeout_beats", int'(beats), 0);

        // Watchdog under stall with rvalid high
        clear_obs();
        stall = 1'b1;
        start_burst(3);
        rvalid = 1'b1;
        check("stall_rready", int'(rready), 0);
        k = 0;
        while (n_to == 0 && k < 20) begin k++; step(); end
        check("stall_timeout_cycle", k, 8);
        check("stall_beats", int'(beats), 0);
        check("stall_no_done", n_done, 0);
        rvalid = 1'b0;
        stall  = 1'b0;
        step();

        // Beat on the would-be timeout cycle wins; request during return is refused
        clear_obs();
        start_burst(0);
        for (int i = 0; i < 7; i++) step();
        rvalid    = 1'b1;
        rlast     = 1'b1;
        req_valid = 1'b1;
        check("late_req_ready_busy", int'(req_ready), 0);
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;
        check("late_beat_done", n_done, 1);
        check("late_beat_no_timeout", n_to, 0);
        check("late_req_not_taken", int'(busy), 0);
        check("late_req_ready", int'(req_ready), 1);
        req_valid = 1'b0;
        step();
        check("late_beats", int'(beats), 1);
        check("late_no_timeout_after", n_to, 0);

        // Reset in the middle of a burst
        clear_obs();
        start_burst(7);
        for (int b = 0; b < 3; b++) begin
            rvalid = 1'b1;
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_arvalid", int'(arvalid), 0);
        check("midrst_rready", int'(rready), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_beats", int'(beats), 0);
        step();
        step();
        rvalid = 1'b0;
        check("midrst_no_pulses", n_done + n_err + n_to, 0);
        rst_n = 1'b1;
        step();
        run_burst(vecs[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
